i2c_mst_arb: RTL

I2C_MST_ARB -- requirements
Module: i2c_mst_arb

---
 rtl/i2c_mst_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/i2c_mst_arb.sv
// Round-robin arbiter that lets NREQ requesters share one I2C master.
// It launches the master through mst_ctrl, waits for busy to rise and then fall, and returns done, err and rdata to the owner.
module i2c_mst_arb #(
  parameter int NREQ   = 2,
  parameter int TO_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [4*NREQ-1:0]    req_len,
  input  logic [128*NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [127:0]         rdata,
  output logic [127:0]         mst_wfifo,
  output logic [15:0]          mst_ctrl,
  input  logic [127:0]         mst_rfifo,
  input  logic [7:0]           mst_status
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FIN} state_t;

  state_t          r_state, w_nxt;
  logic [PW-1:0]   r_ptr, r_own, w_win;
  logic            w_any, r_rd, r_to;
  logic [CW-1:0]   r_cnt;
  logic            w_busy;
  logic            w_unused;

  assign w_busy   = mst_status[7];
  assign w_unused = ^mst_status[6:0];

  // Walk offsets from highest to lowest so that the closest requester at or after r_ptr is assigned last and wins.
  always_comb begin
    int idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        w_win = PW'(idx);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_nxt = S_LAUNCH;
      S_LAUNCH: if (w_busy || r_cnt == TO_LAST) w_nxt = w_busy ? S_RUN : S_FIN;
      S_RUN:    if (!w_busy) w_nxt = S_FIN;
      S_FIN:    w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_own     <= '0;
      r_rd      <= 1'b0;
      r_to      <= 1'b0;
      r_cnt     <= '0;
      gnt       <= '0;
      rdata     <= '0;
      mst_ctrl  <= '0;
      mst_wfifo <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_own     <= w_win;
          gnt       <= NREQ'(1) << w_win;
          r_rd      <= req_rd[w_win];
          mst_ctrl  <= {req_addr[w_win*7 +: 7], req_rd[w_win], 1'b1, 3'b000,
                        req_len[w_win*4 +: 4]};
          mst_wfifo <= req_wdata[w_win*128 +: 128];
          r_cnt     <= '0;
          r_to      <= 1'b0;
        end
        S_LAUNCH: begin
          if (w_busy) begin
            mst_ctrl <= '0;
          end else if (r_cnt == TO_LAST) begin
            mst_ctrl <= '0;
            r_to     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RUN: if (!w_busy && r_rd) rdata <= mst_rfifo;
        S_FIN: begin
          gnt   <= '0;
          r_ptr <= (r_own == PW'(NREQ - 1)) ? '0 : r_own + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // done and err are decoded from the FIN state, so a reset drops them at once.
  assign done = (r_state == S_FIN) ? gnt : '0;
  assign err  = (r_state == S_FIN) && r_to;

endmodule
